// File: rtl/arb_pkg.sv
// Shared types and limits for the arbitrating output-register mux.
// Mode encoding matches the i_mode pin directly.
package arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  localparam int ARB_NUM_CH_MIN = 2;
  localparam int ARB_NUM_CH_MAX = 16;

endpackage

// File: rtl/arb_mux_reg_rr_pick.sv
// Combinational round-robin / fixed-priority picker: rotate the request vector to start, encode lowest set bit.
// Zero latency; no handshake, found=0 when nothing requests.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start,
  input  arb_mode_t         mode,
  output logic [IDX_W-1:0]  winner,
  output logic              found
);

  localparam logic [IDX_W:0] NCH = NUM_CH[IDX_W:0];

  logic [IDX_W-1:0]    base;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [IDX_W-1:0]    off;
  logic [IDX_W:0]      sum;

  always_comb begin
    base  = (mode == ARB_FIXED) ? '0 : start;
    dbl   = {req, req} >> base;
    rot   = dbl[NUM_CH-1:0];
    found = |req;
    off   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    // Offset is relative to base; fold back into 0..NUM_CH-1.
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NCH) sum = sum - NCH;
    winner = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating mux into a single registered valid/ready output stage.
// 1 cycle accept-to-o_valid; o_ready gated by !o_valid | i_ready, so full rate with ready pass-through.
module arb_mux_reg
  import arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_CH     = 4,
  localparam int IDX_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic                         i_mode,
  input  logic [NUM_CH-1:0]            i_valid,
  output logic [NUM_CH-1:0]            o_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [IDX_W-1:0]             o_grant_idx
);

  if (NUM_CH < ARB_NUM_CH_MIN || NUM_CH > ARB_NUM_CH_MAX) begin : g_bad_num_ch
    $error("arb_mux_reg: NUM_CH out of range");
  end

  arb_mode_t             mode;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      winner;
  logic                  found;
  logic                  can_accept;
  logic                  accept;
  logic [DATA_WIDTH-1:0] win_data;
  logic [IDX_W-1:0]      ptr_next;

  assign mode = arb_mode_t'(i_mode);

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req    (i_valid),
    .start  (ptr),
    .mode   (mode),
    .winner (winner),
    .found  (found)
  );

  assign can_accept = !o_valid | i_ready;
  assign accept     = can_accept & found;
  assign ptr_next   = (winner == IDX_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    o_ready = '0;
    if (accept) o_ready[winner] = 1'b1;
    win_data = i_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_grant_idx <= '0;
      ptr         <= '0;
    end else if (accept) begin
      o_valid     <= 1'b1;
      o_data      <= win_data;
      o_grant_idx <= winner;
      if (mode == ARB_RR) ptr <= ptr_next;
    end else if (i_ready) begin
      // Drained with nothing to replace it; data/index hold their last values.
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Randomized and directed bench for arb_mux_reg against a scan-based reference model.
module tb_arb_mux_reg;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          i_mode = 1'b0;
  logic [N-1:0]  i_valid = '0;
  logic [N-1:0]  o_ready;
  logic [N*DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic [IW-1:0] o_grant_idx;

  arb_mux_reg #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .i_mode      (i_mode),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_grant_idx (o_grant_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: priority pointer and the contents of the output register.
  int          m_ptr  = 0;
  bit          m_vld  = 0;
  logic [DW-1:0] m_data = '0;
  int          m_gidx = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input bit mode, input logic [N-1:0] vld);
    int start = mode ? 0 : m_ptr;
    for (int j = 0; j < N; j++) begin
      int k = (start + j) % N;
      if (vld[k]) return k;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_vld = 0; m_data = '0; m_gidx = 0;
  endfunction

  // Entered just after a falling edge; returns with the next falling edge.
  task automatic cycle(input bit mode, input logic [N-1:0] vld, input bit rdy, output int acc);
    int w;
    bit can;
    logic [N-1:0] exp_rdy;
    i_mode = mode; i_valid = vld; i_ready = rdy;
    #1;
    w = pick(mode, vld);
    can = !m_vld || rdy;
    exp_rdy = '0;
    if (can && w >= 0) exp_rdy[w] = 1'b1;
    chk("o_ready", 64'(o_ready), 64'(exp_rdy));
    acc = (can && w >= 0) ? w : -1;
    @(posedge clk);
    if (acc >= 0) begin
      m_vld = 1; m_data = i_data[acc*DW +: DW]; m_gidx = acc;
      if (!mode) m_ptr = (acc + 1) % N;
    end else if (rdy) begin
      m_vld = 0;
    end
    #1;
    chk("o_valid", 64'(o_valid), 64'(m_vld));
    chk("o_data", o_data, m_data);
    chk("o_grant_idx", 64'(o_grant_idx), 64'(m_gidx));
    @(negedge clk);
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] d);
    i_data[ch*DW +: DW] = d;
  endtask

  initial begin
    int acc;
    logic [N-1:0] pend;

    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_data", o_data, 64'd0);
    chk("rst_o_grant_idx", 64'(o_grant_idx), 64'd0);
    @(negedge clk);
    arstn = 1'b1;

    // Round-robin with everyone requesting: 0,1,2,3,0,... one per cycle.
    for (int k = 0; k < N; k++) set_data(k, 64'hA0 + 64'(k));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 4'hF, 1'b1, acc);
      chk("rr_seq_idx", 64'(o_grant_idx), 64'(i % N));
      chk("rr_seq_data", o_data, 64'hA0 + 64'(i % N));
    end

    // Fixed priority: ch1 beats ch3 every time.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'b1010, 1'b1, acc);
      chk("fixed_idx", 64'(o_grant_idx), 64'd1);
    end

    // Backpressure: hold 0x55 from ch2 through a 5-cycle stall, then reload without a bubble.
    set_data(2, 64'h55);
    cycle(1'b0, 4'b0100, 1'b1, acc);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0001, 1'b0, acc);
      chk("stall_data", o_data, 64'h55);
    end
    cycle(1'b0, 4'b0001, 1'b1, acc);
    chk("unstall_idx", 64'(o_grant_idx), 64'd0);

    // Sparse/wrap: ch2 alone sets ptr=3; ch1 then ch0 wrap it back to 1.
    cycle(1'b0, 4'b0100, 1'b1, acc);
    cycle(1'b0, 4'b0010, 1'b1, acc);
    cycle(1'b0, 4'b0001, 1'b1, acc);
    cycle(1'b0, 4'b0000, 1'b1, acc);
    chk("drain_valid", 64'(o_valid), 64'd0);
    cycle(1'b0, 4'hF, 1'b1, acc);
    chk("wrap_next_idx", 64'(o_grant_idx), 64'd1);

    // Mode switch: fixed mode leaves ptr=3 alone; back in RR ch3 is next.
    cycle(1'b0, 4'b0100, 1'b1, acc);
    cycle(1'b1, 4'hF, 1'b1, acc);
    cycle(1'b1, 4'hF, 1'b1, acc);
    chk("mode_fixed_idx", 64'(o_grant_idx), 64'd0);
    cycle(1'b0, 4'hF, 1'b1, acc);
    chk("mode_rr_idx", 64'(o_grant_idx), 64'd3);

    // Random traffic: requests stay asserted with stable data until accepted.
    pend = '0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          set_data(k, {$urandom, $urandom});
        end
      end
      cycle(($urandom_range(0, 3) == 0), pend, ($urandom_range(0, 3) != 0), acc);
      if (acc >= 0) pend[acc] = 1'b0;
    end

    // Mid-stream asynchronous reset drops the beat; ch0 wins first afterwards.
    set_data(1, 64'h1234);
    cycle(1'b0, 4'b0010, 1'b0, acc);
    cycle(1'b0, 4'b0010, 1'b0, acc);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    arstn = 1'b0;
    #1;
    model_reset();
    chk("arst_o_valid", 64'(o_valid), 64'd0);
    chk("arst_o_data", o_data, 64'd0);
    chk("arst_o_grant_idx", 64'(o_grant_idx), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    cycle(1'b0, 4'hF, 1'b1, acc);
    chk("post_rst_idx", 64'(o_grant_idx), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
